// File: rtl/number_property_analyzer.sv
// rtl/number_property_analyzer.sv - classifies a WIDTH-bit operand as even / Fibonacci / binary palindrome
module number_property_analyzer #(
    parameter int WIDTH    = 32,
    parameter int PAL_MODE = 1,
    parameter int CNT_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             go_i,
    input  logic [WIDTH-1:0] number_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             result_valid_o,
    output logic             is_even_o,
    output logic             is_fibonacci_o,
    output logic             is_palindrome_o,
    output logic [CNT_W-1:0] cycles_o,
    output logic [2:0]       state_o
);

    localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_LOAD = 3'd1,
        S_RUN  = 3'd2,
        S_DONE = 3'd3,
        S_HOLD = 3'd4
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] n_q;
    logic             even_q;

    // Fibonacci engine: walks (a,b) up the sequence until it meets or passes n
    logic [WIDTH-1:0] fib_a_q;
    logic [WIDTH-1:0] fib_b_q;
    logic             fib_fin_q;
    logic             fib_res_q;

    // Palindrome engine: i walks down from the top of the span, j walks up from bit 0
    logic [IW-1:0]    pal_i_q;
    logic [IW-1:0]    pal_j_q;
    logic             pal_fin_q;
    logic             pal_res_q;

    logic [CNT_W-1:0] cnt_q;

    // Registered outputs
    logic             busy_q;
    logic             done_q;
    logic             rv_q;
    logic             is_even_q;
    logic             is_fib_q;
    logic             is_pal_q;
    logic [CNT_W-1:0] cycles_q;

    // Next-state helpers
    logic [IW-1:0]    msb_idx_d;
    logic [WIDTH:0]   fib_sum_d;
    logic             fib_hit_d;
    logic             fib_stop_d;
    logic             pal_match_d;
    logic             pal_stop_d;
    logic             fib_done_d;
    logic             pal_done_d;
    logic             fib_final_d;
    logic             pal_final_d;
    logic [CNT_W-1:0] cnt_next_d;

    // Highest set bit of the latched operand; a zero operand maps to index 0
    always_comb begin
        msb_idx_d = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (n_q[k]) begin
                msb_idx_d = k[IW-1:0];
            end
        end
    end

    // One evaluation step of each engine plus the RUN exit condition
    always_comb begin
        // Sum carries one extra bit so an overflowing step can never wrap onto n
        fib_sum_d   = {1'b0, fib_a_q} + {1'b0, fib_b_q};
        fib_hit_d   = (fib_a_q == n_q) || (fib_b_q == n_q);
        fib_stop_d  = fib_hit_d || (fib_b_q > n_q) || fib_sum_d[WIDTH];
        pal_match_d = (pal_i_q <= pal_j_q);
        pal_stop_d  = pal_match_d || (n_q[pal_i_q] != n_q[pal_j_q]);
        fib_done_d  = fib_fin_q || fib_stop_d;
        pal_done_d  = pal_fin_q || pal_stop_d;
        fib_final_d = fib_fin_q ? fib_res_q : fib_hit_d;
        pal_final_d = pal_fin_q ? pal_res_q : pal_match_d;
        cnt_next_d  = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
    end

    // Transaction FSM with both engines and all registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            n_q       <= '0;
            even_q    <= 1'b0;
            fib_a_q   <= '0;
            fib_b_q   <= '0;
            fib_fin_q <= 1'b0;
            fib_res_q <= 1'b0;
            pal_i_q   <= '0;
            pal_j_q   <= '0;
            pal_fin_q <= 1'b0;
            pal_res_q <= 1'b0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rv_q      <= 1'b0;
            is_even_q <= 1'b0;
            is_fib_q  <= 1'b0;
            is_pal_q  <= 1'b0;
            cycles_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (go_i) begin
                        n_q     <= number_i;
                        rv_q    <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    even_q    <= ~n_q[0];
                    fib_a_q   <= '0;
                    fib_b_q   <= WIDTH'(1);
                    fib_fin_q <= 1'b0;
                    fib_res_q <= 1'b0;
                    if (PAL_MODE == 0) begin
                        pal_i_q <= IW'(WIDTH - 1);
                    end else begin
                        pal_i_q <= msb_idx_d;
                    end
                    pal_j_q   <= '0;
                    pal_fin_q <= 1'b0;
                    pal_res_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= S_RUN;
                end
                S_RUN: begin
                    cnt_q <= cnt_next_d;
                    if (!fib_fin_q) begin
                        if (fib_stop_d) begin
                            fib_fin_q <= 1'b1;
                            fib_res_q <= fib_hit_d;
                        end else begin
                            fib_a_q <= fib_b_q;
                            fib_b_q <= fib_sum_d[WIDTH-1:0];
                        end
                    end
                    if (!pal_fin_q) begin
                        if (pal_stop_d) begin
                            pal_fin_q <= 1'b1;
                            pal_res_q <= pal_match_d;
                        end else begin
                            pal_i_q <= pal_i_q - IW'(1);
                            pal_j_q <= pal_j_q + IW'(1);
                        end
                    end
                    // Results are published on the way into DONE so they are valid with done_o
                    if (fib_done_d && pal_done_d) begin
                        is_even_q <= even_q;
                        is_fib_q  <= fib_final_d;
                        is_pal_q  <= pal_final_d;
                        cycles_q  <= cnt_next_d;
                        done_q    <= 1'b1;
                        rv_q      <= 1'b1;
                        state_q   <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_HOLD;
                end
                S_HOLD: begin
                    // A go_i still held from the last request must drop before a new one counts
                    if (!go_i) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy_o          = busy_q;
    assign done_o          = done_q;
    assign result_valid_o  = rv_q;
    assign is_even_o       = is_even_q;
    assign is_fibonacci_o  = is_fib_q;
    assign is_palindrome_o = is_pal_q;
    assign cycles_o        = cycles_q;
    assign state_o         = state_q;

endmodule

// File: tb/tb_number_property_analyzer.sv
// tb/tb_number_property_analyzer.sv - self-checking bench for number_property_analyzer
module tb_number_property_analyzer;

    logic        clk;
    logic        reset;
    logic        go;
    logic [31:0] number;

    logic        busy_v [3];
    logic        done_v [3];
    logic        rv_v   [3];
    logic        even_v [3];
    logic        fib_v  [3];
    logic        pal_v  [3];
    logic [2:0]  st_v   [3];
    logic [7:0]  cyc0;
    logic [7:0]  cyc1;
    logic [2:0]  cyc2;

    int n_cmp  = 0;
    int n_fail = 0;

    typedef struct {
        logic even;
        logic fib;
        logic pal;
        int   raw;
        int   sat;
    } exp_t;

    typedef struct {
        logic [31:0] n;
        logic        even;
        logic        fib;
        logic        pal1;
        logic        pal0;
        int          cyc;
    } vec_t;

    number_property_analyzer #(.WIDTH(32), .PAL_MODE(1), .CNT_W(8)) u_d0 (
        .clk(clk), .reset(reset), .go_i(go), .number_i(number),
        .busy_o(busy_v[0]), .done_o(done_v[0]), .result_valid_o(rv_v[0]),
        .is_even_o(even_v[0]), .is_fibonacci_o(fib_v[0]), .is_palindrome_o(pal_v[0]),
        .cycles_o(cyc0), .state_o(st_v[0])
    );

    number_property_analyzer #(.WIDTH(32), .PAL_MODE(0), .CNT_W(8)) u_d1 (
        .clk(clk), .reset(reset), .go_i(go), .number_i(number),
        .busy_o(busy_v[1]), .done_o(done_v[1]), .result_valid_o(rv_v[1]),
        .is_even_o(even_v[1]), .is_fibonacci_o(fib_v[1]), .is_palindrome_o(pal_v[1]),
        .cycles_o(cyc1), .state_o(st_v[1])
    );

    number_property_analyzer #(.WIDTH(8), .PAL_MODE(1), .CNT_W(3)) u_d2 (
        .clk(clk), .reset(reset), .go_i(go), .number_i(number[7:0]),
        .busy_o(busy_v[2]), .done_o(done_v[2]), .result_valid_o(rv_v[2]),
        .is_even_o(even_v[2]), .is_fibonacci_o(fib_v[2]), .is_palindrome_o(pal_v[2]),
        .cycles_o(cyc2), .state_o(st_v[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (got timeout, required completion)");
        $fatal(1);
    end

    function automatic logic [7:0] cyc_of(input int i);
        case (i)
            0:       return cyc0;
            1:       return cyc1;
            default: return {5'b0, cyc2};
        endcase
    endfunction

    // Reference: results and engine finish cycles derived directly from the rules
    function automatic exp_t model(input logic [31:0] num, input int w, input int pm, input int cw);
        exp_t   r;
        longint n, a, b, t, lim;
        int     fc, pc, len, msb;
        lim   = longint'(1) << w;
        n     = longint'(num) & (lim - 1);
        r.even = (n % 2 == 0);
        a = 0; b = 1; fc = 0; r.fib = 1'b0;
        for (int k = 1; k <= 200; k++) begin
            if (a == n || b == n) begin r.fib = 1'b1; fc = k; break; end
            if (b > n || a + b >= lim) begin r.fib = 1'b0; fc = k; break; end
            t = a + b; a = b; b = t;
        end
        msb = 0;
        for (int k = 0; k < w; k++) if (((n >> k) & 1) != 0) msb = k;
        len   = (pm == 1) ? msb + 1 : w;
        r.pal = 1'b1;
        pc    = len / 2 + 1;
        for (int k = 0; k < len / 2; k++) begin
            if (((n >> (len - 1 - k)) & 1) != ((n >> k) & 1)) begin
                r.pal = 1'b0; pc = k + 1; break;
            end
        end
        r.raw = (fc > pc) ? fc : pc;
        r.sat = (r.raw > (1 << cw) - 1) ? (1 << cw) - 1 : r.raw;
        return r;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Full handshake on all three instances; go_i stays high through HOLD
    task automatic run_txn(input logic [31:0] val, input bit disturb);
        exp_t m [3];
        int   lat [3];
        int   pulses [3];
        int   cyc;
        bit   all_hold;
        m[0] = model(val, 32, 1, 8);
        m[1] = model(val, 32, 0, 8);
        m[2] = model(val, 8, 1, 3);
        for (int i = 0; i < 3; i++) begin lat[i] = -1; pulses[i] = 0; end
        @(negedge clk);
        number = val;
        go     = 1'b1;
        cyc      = 0;
        all_hold = 1'b0;
        while (!all_hold && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (disturb && cyc == 3) begin number = ~val; go = 1'b0; end
            if (disturb && cyc == 4) begin number = val ^ 32'h5a5a_0f0f; go = 1'b1; end
            for (int i = 0; i < 3; i++) begin
                if (done_v[i]) begin
                    pulses[i]++;
                    if (lat[i] < 0) lat[i] = cyc;
                end
            end
            if (cyc == 1) begin
                check("load_busy", busy_v[0], 1);
                check("load_rv_cleared", rv_v[0], 0);
                check("load_state", st_v[0], 1);
            end
            all_hold = (st_v[0] == 3'd4) && (st_v[1] == 3'd4) && (st_v[2] == 3'd4);
        end
        check("txn_reached_hold", all_hold, 1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) if (done_v[i]) pulses[i]++;
        end
        for (int i = 0; i < 3; i++) begin
            check($sformatf("even[%0d] n=%0d", i, val), even_v[i], m[i].even);
            check($sformatf("fib[%0d] n=%0d", i, val), fib_v[i], m[i].fib);
            check($sformatf("pal[%0d] n=%0d", i, val), pal_v[i], m[i].pal);
            check($sformatf("cycles[%0d] n=%0d", i, val), cyc_of(i), m[i].sat);
            check($sformatf("latency[%0d] n=%0d", i, val), lat[i], 2 + m[i].raw);
            check($sformatf("done_pulses[%0d]", i), pulses[i], 1);
            check($sformatf("hold_state[%0d]", i), st_v[i], 4);
            check($sformatf("hold_rv[%0d]", i), rv_v[i], 1);
            check($sformatf("hold_busy[%0d]", i), busy_v[i], 0);
        end
        go = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("idle_state[%0d]", i), st_v[i], 0);
            check($sformatf("idle_rv[%0d]", i), rv_v[i], 1);
        end
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("%s_state[%0d]", tag, i), st_v[i], 0);
            check($sformatf("%s_busy[%0d]", tag, i), busy_v[i], 0);
            check($sformatf("%s_done[%0d]", tag, i), done_v[i], 0);
            check($sformatf("%s_rv[%0d]", tag, i), rv_v[i], 0);
            check($sformatf("%s_even[%0d]", tag, i), even_v[i], 0);
            check($sformatf("%s_fib[%0d]", tag, i), fib_v[i], 0);
            check($sformatf("%s_pal[%0d]", tag, i), pal_v[i], 0);
            check($sformatf("%s_cycles[%0d]", tag, i), cyc_of(i), 0);
        end
    endtask

    initial begin
        vec_t        tbl [8];
        logic [31:0] rv;
        int          cyc;

        tbl[0] = '{n: 32'd55,  even: 0, fib: 1, pal1: 0, pal0: 0, cyc: 10};
        tbl[1] = '{n: 32'd9,   even: 0, fib: 0, pal1: 1, pal0: 0, cyc: 7};
        tbl[2] = '{n: 32'd0,   even: 1, fib: 1, pal1: 1, pal0: 1, cyc: 1};
        tbl[3] = '{n: 32'd1,   even: 0, fib: 1, pal1: 1, pal0: 0, cyc: 1};
        tbl[4] = '{n: 32'd233, even: 0, fib: 1, pal1: 0, pal0: 0, cyc: 13};
        tbl[5] = '{n: 32'd144, even: 1, fib: 1, pal1: 0, pal0: 0, cyc: 12};
        tbl[6] = '{n: 32'd255, even: 0, fib: 0, pal1: 1, pal0: 0, cyc: 14};
        tbl[7] = '{n: 32'd5,   even: 0, fib: 1, pal1: 1, pal0: 0, cyc: 5};

        reset  = 1'b1;
        go     = 1'b0;
        number = '0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        reset = 1'b0;

        for (int t = 0; t < 8; t++) begin
            run_txn(tbl[t].n, 1'b0);
            check($sformatf("tbl_even n=%0d", tbl[t].n), even_v[0], tbl[t].even);
            check($sformatf("tbl_fib n=%0d", tbl[t].n), fib_v[0], tbl[t].fib);
            check($sformatf("tbl_pal1 n=%0d", tbl[t].n), pal_v[0], tbl[t].pal1);
            check($sformatf("tbl_cycles n=%0d", tbl[t].n), cyc0, tbl[t].cyc);
            check($sformatf("tbl_pal0 n=%0d", tbl[t].n), pal_v[1], tbl[t].pal0);
            check($sformatf("tbl_w8_even n=%0d", tbl[t].n), even_v[2], tbl[t].even);
            check($sformatf("tbl_w8_fib n=%0d", tbl[t].n), fib_v[2], tbl[t].fib);
            check($sformatf("tbl_w8_pal n=%0d", tbl[t].n), pal_v[2], tbl[t].pal1);
        end

        // Reset in the fourth RUN cycle of n=55, then a fresh request with n=1
        @(negedge clk);
        number = 32'd55;
        go     = 1'b1;
        cyc    = 0;
        while (st_v[0] != 3'd2 && cyc < 20) begin @(negedge clk); cyc++; end
        check("rst_reached_run", st_v[0], 2);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_all_zero("midrun_rst");
        @(negedge clk);
        reset = 1'b0;
        go    = 1'b0;
        run_txn(32'd1, 1'b0);
        check("post_rst_even", even_v[0], 0);
        check("post_rst_fib", fib_v[0], 1);
        check("post_rst_pal", pal_v[0], 1);

        // Operand and go_i disturbed mid-transaction
        run_txn(32'd55, 1'b1);
        check("disturb_fib", fib_v[0], 1);
        check("disturb_cycles", cyc0, 10);

        for (int it = 0; it < 20; it++) begin
            if (it % 4 == 0) rv = $urandom_range(0, 400);
            else if (it % 4 == 1) rv = $urandom & 32'h0000_ffff;
            else rv = $urandom;
            run_txn(rv, it[0]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
